mercan_gucuk_p1: RTL and testbench



---
 rtl/mercan_gucuk_p1.sv | 71 +++++++
 tb/tb_mercan_gucuk_p1.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mercan_gucuk_p1.sv
// Fetch-stage program counter: holds the PC, steps it every cycle, and loads a redirect target.
// Build option: define PC_ALIGN_CHECK_EN to word-align redirect targets and flag misaligned ones.
module mercan_gucuk_p1 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_update_fetch,
  input  logic [31:0] pc_new_fetch,
  output logic [31:0] pc_fetch,
  output logic [31:0] pc_plus4_fetch,
  output logic [29:0] pc_word_fetch,
  output logic        pc_misaligned_fetch
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic [31:0] pc_next_seq;
  logic [31:0] pc_redirect;

  // Sequential step wraps modulo 2^32 with no overflow indication.
  assign pc_next_seq = pc_q + PC_STEP;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_d;
  logic misaligned_q;

  assign pc_redirect = {pc_new_fetch[31:2], 2'b00};

  always_comb begin
    misaligned_d = 1'b0;
    if (pc_update_fetch) begin
      misaligned_d = (pc_new_fetch[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_misaligned_fetch = misaligned_q;
`else
  assign pc_redirect         = pc_new_fetch;
  assign pc_misaligned_fetch = 1'b0;
`endif

  always_comb begin
    pc_d = pc_next_seq;
    if (pc_update_fetch) begin
      pc_d = pc_redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_fetch       = pc_q;
  assign pc_plus4_fetch = pc_next_seq;
  assign pc_word_fetch  = pc_q[31:2];

endmodule

// File: tb/tb_mercan_gucuk_p1.sv
// Self-checking bench for the fetch PC unit: a reference model pushes the expected PC/flag
// for every driven cycle, and the value is popped and compared one edge later.
module tb_mercan_gucuk_p1;

  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pc_update_fetch;
  logic [31:0] pc_new_fetch;
  logic [31:0] pc_fetch;
  logic [31:0] pc_plus4_fetch;
  logic [29:0] pc_word_fetch;
  logic        pc_misaligned_fetch;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb_q[$];
  logic [31:0] model_pc;
  logic        model_mis;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  mercan_gucuk_p1 dut (
    .clk                 (clk),
    .reset               (reset),
    .pc_update_fetch     (pc_update_fetch),
    .pc_new_fetch        (pc_new_fetch),
    .pc_fetch            (pc_fetch),
    .pc_plus4_fetch      (pc_plus4_fetch),
    .pc_word_fetch       (pc_word_fetch),
    .pc_misaligned_fetch (pc_misaligned_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge state, then compare after the edge.
  task automatic step(input logic rst_n, input logic upd, input logic [31:0] npc);
    exp_t e;
    exp_t got;
    reset           = rst_n;
    pc_update_fetch = upd;
    pc_new_fetch    = npc;
    if (!rst_n) begin
      model_pc  = 32'h0;
      model_mis = 1'b0;
    end else if (upd) begin
      model_pc  = ALIGN ? (npc & 32'hFFFF_FFFC) : npc;
      model_mis = ALIGN ? (npc[1:0] != 2'b00) : 1'b0;
    end else begin
      model_pc  = model_pc + 32'd4;
      model_mis = 1'b0;
    end
    e.pc  = model_pc;
    e.mis = model_mis;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("pc_fetch", pc_fetch, got.pc);
    check("pc_plus4", pc_plus4_fetch, got.pc + 32'd4);
    check("pc_word", {2'b00, pc_word_fetch}, {2'b00, got.pc[31:2]});
    check("misaligned", {31'b0, pc_misaligned_fetch}, {31'b0, got.mis});
  endtask

  initial begin
    reset           = 1'b0;
    pc_update_fetch = 1'b0;
    pc_new_fetch    = 32'h0;
    model_pc        = 32'h0;
    model_mis       = 1'b0;
    @(negedge clk);

    // Reset with arbitrary inputs
    step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, $urandom);
    check("rst_pc", pc_fetch, 32'h0);
    check("rst_word", {2'b00, pc_word_fetch}, 32'h0);
    check("rst_plus4", pc_plus4_fetch, 32'h4);

    // Release with redirect to 0, then free-run 12 cycles
    step(1'b1, 1'b1, 32'h0);
    check("rel_pc", pc_fetch, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, $urandom);
      check("seq_pc", pc_fetch, 32'(i * 4));
      check("seq_word", {2'b00, pc_word_fetch}, 32'(i));
    end

    // Single-cycle redirect
    step(1'b1, 1'b1, 32'h0000_0100);
    check("redir_pc", pc_fetch, 32'h100);
    step(1'b1, 1'b0, 32'h0);
    check("redir_p1", pc_fetch, 32'h104);
    step(1'b1, 1'b0, 32'h0);
    check("redir_p2", pc_fetch, 32'h108);

    // Held redirect keeps the PC constant
    step(1'b1, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b1, 32'h0000_0040);
    check("hold_pc", pc_fetch, 32'h40);

    // Reset beats redirect
    step(1'b0, 1'b1, 32'h0000_0200);
    check("rst_win", pc_fetch, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200);
    check("post_rst", pc_fetch, 32'h200);

    // Wraparound
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc", pc_fetch, 32'hFFFF_FFFC);
    check("wrap_p4", pc_plus4_fetch, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("wrap_nxt", pc_fetch, 32'h0);

    // Misaligned redirect
    step(1'b1, 1'b1, 32'h0000_0106);
    check("mis_pc", pc_fetch, ALIGN ? 32'h104 : 32'h106);
    check("mis_flag", {31'b0, pc_misaligned_fetch}, {31'b0, ALIGN});
    step(1'b1, 1'b0, 32'h0);
    check("mis_nxt", pc_fetch, ALIGN ? 32'h108 : 32'h10A);
    check("mis_clr", {31'b0, pc_misaligned_fetch}, 32'h0);

    // Misaligned redirect followed by reset clears the flag
    step(1'b1, 1'b1, 32'h0000_0333);
    step(1'b0, 1'b0, 32'h0);
    check("mis_rst", {31'b0, pc_misaligned_fetch}, 32'h0);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0), $urandom);
    end

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
